// File: rtl/bcd_display_counter_if.sv
// Control and display bus for bcd_display_counter.
// master: drives enable/up_down/clear/load/load_value and observes the count and display.
// slave : the counter itself; drives count_bcd, wrap, segments, digit_sel, slow_clk.
interface bcd_display_counter_if #(
  parameter int unsigned NUM_DIGITS = 4
);
  logic                      enable;
  logic                      up_down;
  logic                      clear;
  logic                      load;
  logic [4*NUM_DIGITS-1:0]   load_value;
  logic [4*NUM_DIGITS-1:0]   count_bcd;
  logic                      wrap;
  logic [6:0]                segments;
  logic [NUM_DIGITS-1:0]     digit_sel;
  logic                      slow_clk;

  modport master (
    output enable, up_down, clear, load, load_value,
    input  count_bcd, wrap, segments, digit_sel, slow_clk
  );

  modport slave (
    input  enable, up_down, clear, load, load_value,
    output count_bcd, wrap, segments, digit_sel, slow_clk
  );
endinterface

// File: rtl/bcd_display_counter.sv
// Multi-digit BCD up/down counter with prescaled tick and a multiplexed 7-segment scan driver.
// Ports: clk, reset_n (async active-low), bus (slave modport): enable, up_down, clear, load,
//        load_value in; count_bcd, wrap, segments, digit_sel, slow_clk out.
module bcd_display_counter #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned MAX_COUNT  = 1000,
  parameter int unsigned SCAN_DIV   = 16,
  parameter int unsigned SLOW_BIT   = 4,
  parameter bit          BLANK_LZ   = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  bcd_display_counter_if.slave  bus
);

  localparam int unsigned CW = 4 * NUM_DIGITS;
  localparam int unsigned PW = $clog2(MAX_COUNT + 1);
  localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [PW-1:0]         pre_q;
  logic [CW-1:0]         count_q;
  logic                  wrap_q;
  logic [SW-1:0]         div_q;
  logic [IW-1:0]         idx_q;

  logic                  tick_c;
  logic [CW-1:0]         count_step_c;
  logic                  wrap_step_c;
  logic [CW-1:0]         load_clean_c;
  logic [NUM_DIGITS-1:0] lead_zero_c;
  logic [3:0]            digit_c;
  logic [6:0]            seg_c;

  assign tick_c = bus.enable && (pre_q == PW'(MAX_COUNT));

  // Ripple carry/borrow through the digits; a carry out of the top digit is the wrap.
  always_comb begin
    logic       carry;
    logic [3:0] d;
    count_step_c = count_q;
    carry        = 1'b1;
    d            = 4'd0;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      d = count_q[4*i +: 4];
      if (carry) begin
        if (bus.up_down) begin
          if (d >= 4'd9) begin
            count_step_c[4*i +: 4] = 4'd0;
          end else begin
            count_step_c[4*i +: 4] = d + 4'd1;
            carry                  = 1'b0;
          end
        end else begin
          if (d == 4'd0) begin
            count_step_c[4*i +: 4] = 4'd9;
          end else begin
            count_step_c[4*i +: 4] = d - 4'd1;
            carry                  = 1'b0;
          end
        end
      end
    end
    wrap_step_c = carry;
  end

  // Clamp non-decimal load nibbles to 9.
  always_comb begin
    load_clean_c = bus.load_value;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (bus.load_value[4*i +: 4] > 4'd9) load_clean_c[4*i +: 4] = 4'd9;
    end
  end

  // Prescaler, count and wrap pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_q   <= '0;
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else if (bus.clear) begin
      pre_q   <= '0;
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else if (bus.load) begin
      pre_q   <= '0;
      count_q <= load_clean_c;
      wrap_q  <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      if (bus.enable) pre_q <= tick_c ? '0 : pre_q + PW'(1);
      if (tick_c) begin
        count_q <= count_step_c;
        wrap_q  <= wrap_step_c;
      end
    end
  end

  // Scan divider and digit index; free-running regardless of enable/clear/load.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q <= '0;
      idx_q <= '0;
    end else if (div_q == SW'(SCAN_DIV - 1)) begin
      div_q <= '0;
      idx_q <= (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + IW'(1);
    end else begin
      div_q <= div_q + SW'(1);
    end
  end

  // lead_zero_c[i]: digit i and every digit above it are zero.
  always_comb begin
    logic all_zero;
    all_zero    = 1'b1;
    lead_zero_c = '0;
    for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
      all_zero       = all_zero && (count_q[4*i +: 4] == 4'd0);
      lead_zero_c[i] = all_zero;
    end
  end

  assign digit_c = count_q[{idx_q, 2'b00} +: 4];

  // Segment decode of the selected digit, with optional leading-zero blanking.
  always_comb begin
    seg_c = 7'h00;
    case (digit_c)
      4'd0: seg_c = 7'h3F;
      4'd1: seg_c = 7'h06;
      4'd2: seg_c = 7'h5B;
      4'd3: seg_c = 7'h4F;
      4'd4: seg_c = 7'h66;
      4'd5: seg_c = 7'h6D;
      4'd6: seg_c = 7'h7D;
      4'd7: seg_c = 7'h07;
      4'd8: seg_c = 7'h7F;
      4'd9: seg_c = 7'h6F;
      default: seg_c = 7'h00;
    endcase
    if (BLANK_LZ && (idx_q != '0) && lead_zero_c[idx_q]) seg_c = 7'h00;
  end

  assign bus.count_bcd = count_q;
  assign bus.wrap      = wrap_q;
  assign bus.segments  = seg_c;
  assign bus.digit_sel = NUM_DIGITS'(1) << idx_q;
  assign bus.slow_clk  = pre_q[SLOW_BIT];

endmodule

// File: tb/tb_bcd_display_counter.sv
// Self-checking bench for bcd_display_counter: directed scenarios plus randomized traffic,
// checked every cycle against a decimal-arithmetic reference model.
module tb_bcd_display_counter;

  localparam int unsigned ND   = 3;
  localparam int unsigned MAXC = 3;
  localparam int unsigned SD   = 2;
  localparam int unsigned SB   = 1;
  localparam int          MODV = 1000;

  logic clk;
  logic reset_n;
  int   checks;
  int   failures;

  bcd_display_counter_if #(.NUM_DIGITS(ND)) bus ();

  bcd_display_counter #(
    .NUM_DIGITS(ND), .MAX_COUNT(MAXC), .SCAN_DIV(SD), .SLOW_BIT(SB), .BLANK_LZ(1'b1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: plain integers.
  int m_val, m_pre, m_wrap, m_div, m_idx;
  int seg_tab [10] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07, 'h7F, 'h6F};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    logic [11:0] r;
    int p;
    r = '0;
    p = 1;
    for (int i = 0; i < int'(ND); i++) begin
      r[4*i +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  function automatic int from_load(input logic [11:0] lv);
    int v, p, n;
    v = 0;
    p = 1;
    for (int i = 0; i < int'(ND); i++) begin
      n = int'(lv[4*i +: 4]);
      if (n > 9) n = 9;
      v = v + n * p;
      p = p * 10;
    end
    return v;
  endfunction

  task automatic model_reset();
    m_val = 0; m_pre = 0; m_wrap = 0; m_div = 0; m_idx = 0;
  endtask

  // One clock edge of the reference, using the inputs applied before the edge.
  task automatic model_edge();
    int tick;
    tick = (bus.enable && m_pre == int'(MAXC)) ? 1 : 0;
    if (bus.clear) begin
      m_val = 0; m_pre = 0; m_wrap = 0;
    end else if (bus.load) begin
      m_val = from_load(bus.load_value); m_pre = 0; m_wrap = 0;
    end else begin
      m_wrap = 0;
      if (bus.enable) m_pre = tick ? 0 : m_pre + 1;
      if (tick) begin
        if (bus.up_down) begin
          m_wrap = (m_val == MODV - 1) ? 1 : 0;
          m_val  = (m_val + 1) % MODV;
        end else begin
          m_wrap = (m_val == 0) ? 1 : 0;
          m_val  = (m_val + MODV - 1) % MODV;
        end
      end
    end
    if (m_div == int'(SD) - 1) begin
      m_div = 0;
      m_idx = (m_idx + 1) % int'(ND);
    end else begin
      m_div = m_div + 1;
    end
  endtask

  task automatic check_all(input string tag);
    int p, dg, seg;
    p   = 10 ** m_idx;
    dg  = (m_val / p) % 10;
    seg = (m_idx > 0 && m_val < p) ? 0 : seg_tab[dg];
    chk({tag, ".count"}, 32'(bus.count_bcd), 32'(to_bcd(m_val)));
    chk({tag, ".wrap"},  32'(bus.wrap),      32'(m_wrap));
    chk({tag, ".dsel"},  32'(bus.digit_sel), 32'(1 << m_idx));
    chk({tag, ".seg"},   32'(bus.segments),  32'(seg));
    chk({tag, ".slow"},  32'(bus.slow_clk),  32'((m_pre >> SB) & 1));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset_n  = 1'b0;
    bus.enable = 1'b0; bus.up_down = 1'b1; bus.clear = 1'b0; bus.load = 1'b0;
    bus.load_value = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("rst");
    chk("rst.seg_const", 32'(bus.segments), 32'h3F);
    reset_n = 1'b1;

    // Basic counting up: 11 ticks in 45 clocks.
    bus.enable = 1'b1; bus.up_down = 1'b1;
    for (int i = 0; i < 45; i++) step("up");
    chk("up45.count", 32'(bus.count_bcd), 32'h011);

    // Roll-over from 999.
    bus.load = 1'b1; bus.load_value = 12'h999;
    step("ld999");
    bus.load = 1'b0;
    for (int i = 0; i < 4; i++) step("roll");
    chk("roll.count", 32'(bus.count_bcd), 32'h000);
    chk("roll.wrap",  32'(bus.wrap), 32'h1);
    step("roll_after");

    // Roll-under from 000.
    bus.load = 1'b1; bus.load_value = 12'h000; bus.up_down = 1'b0;
    step("ld000");
    bus.load = 1'b0;
    for (int i = 0; i < 4; i++) step("under");
    chk("under.count", 32'(bus.count_bcd), 32'h999);
    chk("under.wrap",  32'(bus.wrap), 32'h1);
    step("under_after");

    // Clear beats load; nibble clamping; enable hold.
    bus.up_down = 1'b1;
    bus.clear = 1'b1; bus.load = 1'b1; bus.load_value = 12'h555;
    step("clr_ld");
    chk("clr_ld.count", 32'(bus.count_bcd), 32'h000);
    bus.clear = 1'b0; bus.load_value = 12'h0A7;
    step("clamp");
    chk("clamp.count", 32'(bus.count_bcd), 32'h097);
    bus.load = 1'b0;
    for (int i = 0; i < 4; i++) step("post_ld");
    bus.enable = 1'b0;
    for (int i = 0; i < 20; i++) step("hold");
    chk("hold.count", 32'(bus.count_bcd), 32'h098);
    bus.enable = 1'b1;

    // Blanking view: 005 and 105.
    bus.load = 1'b1; bus.load_value = 12'h005;
    step("ld005");
    bus.load = 1'b0; bus.enable = 1'b0;
    for (int i = 0; i < 6; i++) step("blank005");
    bus.load = 1'b1; bus.load_value = 12'h105;
    step("ld105");
    bus.load = 1'b0;
    for (int i = 0; i < 6; i++) step("blank105");
    bus.enable = 1'b1;

    // Asynchronous reset between edges, mid-prescale.
    bus.load = 1'b1; bus.load_value = 12'h321;
    step("ld321");
    bus.load = 1'b0;
    step("pre1");
    step("pre2");
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all("arst");
    chk("arst.seg_const", 32'(bus.segments), 32'h3F);
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) step("resume");
    chk("resume.count", 32'(bus.count_bcd), 32'h002);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      bus.enable  = ($urandom_range(0, 7) != 0);
      bus.up_down = ($urandom_range(0, 1) != 0);
      bus.clear   = ($urandom_range(0, 63) == 0);
      bus.load    = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 2) == 0)
        bus.load_value = bus.up_down ? 12'h998 : 12'h001;
      else
        bus.load_value = 12'($urandom);
      step("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
